// File: rtl/spi_reg_ctrl_if.sv
// Bus bundle between the SPI byte engine / register bank and spi_reg_ctrl.
// "slave" is the controller's view and "master" is the environment's view.
interface spi_reg_ctrl_if #(
    parameter int D_W    = 8,
    parameter int ADDR_W = 4
);
    logic              cs_active;
    logic              rx_valid;
    logic [D_W-1:0]    rx_data;
    logic [D_W-1:0]    tx_data;
    logic [ADDR_W-1:0] reg_addr;
    logic [D_W-1:0]    reg_wdata;
    logic              reg_wr_en;
    logic [D_W-1:0]    reg_rdata;
    logic              busy;

    modport slave (
        input  cs_active, rx_valid, rx_data, reg_rdata,
        output tx_data, reg_addr, reg_wdata, reg_wr_en, busy
    );

    modport master (
        output cs_active, rx_valid, rx_data, reg_rdata,
        input  tx_data, reg_addr, reg_wdata, reg_wr_en, busy
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI register-access controller.
// The first byte of a transaction is a command: bit D_W-1 selects write (1) or
// read (0), and the low ADDR_W bits give the register address. Following bytes
// are write data (write) or dummy bytes that clock out read data (read).
// Optional feature: define SPI_REG_AUTOINC_EN to step the register address
// after every data byte (wrapping at the top of the bank).
// ADDR_W must not exceed D_W-1 so the address never overlaps the direction bit.
module spi_reg_ctrl #(
    parameter int D_W    = 8,
    parameter int ADDR_W = 4
) (
    input  logic          m_clk,
    input  logic          rst,
    spi_reg_ctrl_if.slave bus
);

`ifdef SPI_REG_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    // Byte presented to the SPI master as soon as a transaction opens.
    localparam logic [D_W-1:0] SYNC_BYTE = D_W'(8'hA5);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [D_W-1:0]    tx_q, tx_next;
    logic [D_W-1:0]    wdata_q, wdata_next;
    logic [ADDR_W-1:0] addr_q, addr_next;
    logic              wr_en_q, wr_en_next;
    // Set on the edge that accepts a read byte; the following edge captures
    // reg_rdata, which by then reflects the freshly updated address. This
    // gives the two-cycle pulse-to-tx_data latency.
    logic              load_q, load_next;

    // State and datapath registers; reset wins over everything, including a
    // write strobe that was about to be issued.
    always_ff @(posedge m_clk) begin
        if (rst) begin
            state   <= IDLE;
            tx_q    <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            wr_en_q <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state   <= state_next;
            tx_q    <= tx_next;
            wdata_q <= wdata_next;
            addr_q  <= addr_next;
            wr_en_q <= wr_en_next;
            load_q  <= load_next;
        end
    end

    // Next-state and datapath decisions for the command/data protocol.
    always_comb begin
        state_next = state;
        tx_next    = tx_q;
        wdata_next = wdata_q;
        addr_next  = addr_q;
        wr_en_next = 1'b0;
        load_next  = 1'b0;

        // Deferred read-data capture from the previous accepted read byte.
        if (load_q) begin
            tx_next = bus.reg_rdata;
        end

        // Post-write increment lands on the edge that ends the strobe, so the
        // strobe itself always carries the address the byte was meant for.
        if (AUTOINC && wr_en_q) begin
            addr_next = addr_q + ADDR_W'(1);
        end

        case (state)
            IDLE: begin
                // rx_valid is ignored here; only chip select opens a transaction.
                if (bus.cs_active) begin
                    state_next = CMD;
                    tx_next    = SYNC_BYTE;
                end
            end

            CMD: begin
                if (bus.rx_valid) begin
                    addr_next = bus.rx_data[ADDR_W-1:0];
                    if (bus.rx_data[D_W-1]) begin
                        state_next = WDATA;
                    end else begin
                        state_next = RDATA;
                        load_next  = 1'b1;
                    end
                end
                if (!bus.cs_active) begin
                    state_next = IDLE;
                end
            end

            WDATA: begin
                // A byte that arrives together with chip select falling is
                // still written: stay one more cycle so the strobe happens
                // inside WDATA, then leave. Once the strobe is out, a closed
                // chip select ends the transaction and no new byte is taken.
                if (!bus.cs_active && (wr_en_q || !bus.rx_valid)) begin
                    state_next = IDLE;
                end else if (bus.rx_valid) begin
                    wr_en_next = 1'b1;
                    wdata_next = bus.rx_data;
                end
            end

            RDATA: begin
                // Byte content is don't-care; each one fetches the next value.
                if (bus.rx_valid) begin
                    if (AUTOINC) begin
                        addr_next = addr_q + ADDR_W'(1);
                    end
                    load_next = 1'b1;
                end
                if (!bus.cs_active) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.tx_data   = tx_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_wr_en = wr_en_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: stimulus pushes expected register writes
// and expected tx_data values (with the cycle they must appear) into queues;
// an independent monitor pops and compares as the DUT produces them.
module tb_spi_reg_ctrl;
    localparam int D_W    = 8;
    localparam int ADDR_W = 4;
    localparam int NREG   = 16;

`ifdef SPI_REG_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic m_clk = 1'b0;
    logic rst   = 1'b1;

    spi_reg_ctrl_if #(.D_W(D_W), .ADDR_W(ADDR_W)) bus ();

    spi_reg_ctrl #(.D_W(D_W), .ADDR_W(ADDR_W)) dut (
        .m_clk (m_clk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 m_clk = ~m_clk;

    int cyc = 0;
    always @(posedge m_clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int due; int data; int prev; } rd_t;
    wr_t wr_q[$];
    rd_t rd_q[$];

    // Register bank mock driven by the DUT, and the bench's own model of it.
    logic [7:0] init_vals [NREG];
    logic [7:0] bank      [NREG];
    int         mdl       [NREG];
    int         exp_tx = 0;

    assign bus.reg_rdata = bank[bus.reg_addr];

    always @(posedge m_clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) bank[i] <= init_vals[i];
        end else if (bus.reg_wr_en) begin
            bank[bus.reg_addr] <= bus.reg_wdata;
        end
    end

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: consume write strobes and timed tx_data expectations.
    always @(negedge m_clk) begin
        wr_t w;
        rd_t r;
        if (!rst) begin
            if (bus.reg_wr_en) begin
                if (wr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stray_strobe: got reg_wr_en=1 addr %0h want no strobe (cycle %0d)",
                             bus.reg_addr, cyc);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", int'(bus.reg_addr), w.addr);
                    chk("wr_data", int'(bus.reg_wdata), w.data);
                end
            end
            if (rd_q.size() > 0 && rd_q[0].due == cyc + 1) begin
                chk("tx_before_due", int'(bus.tx_data), rd_q[0].prev);
            end
            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                r = rd_q.pop_front();
                chk("tx_data", int'(bus.tx_data), r.data);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge m_clk);
            #1;
        end
    endtask

    task automatic push_tx(int due, int val);
        rd_t r;
        r.due  = due;
        r.data = val;
        r.prev = exp_tx;
        rd_q.push_back(r);
        exp_tx = val;
    endtask

    task automatic push_wr(int a, int d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wr_q.push_back(w);
        mdl[a] = d;
    endtask

    function automatic int next_addr(int a);
        return AUTOINC ? (a + 1) % NREG : a;
    endfunction

    task automatic pulse(int d, int gap);
        bus.rx_data  = 8'(d);
        bus.rx_valid = 1'b1;
        tick(1);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        tick(gap);
    endtask

    task automatic cs_open();
        bus.cs_active = 1'b1;
        push_tx(cyc + 1, 'hA5);
        tick(2);
    endtask

    task automatic cs_close();
        bus.cs_active = 1'b0;
        tick(1);
        chk("busy_after_close", int'(bus.busy), 0);
        tick(1);
    endtask

    task automatic write_txn(int a, int pad, int d[$]);
        cs_open();
        pulse('h80 | (pad << 4) | a, 2);
        foreach (d[i]) begin
            push_wr(a, d[i]);
            a = next_addr(a);
            pulse(d[i], $urandom_range(2, 4));
        end
        chk("busy_in_write", int'(bus.busy), 1);
        cs_close();
    endtask

    task automatic read_txn(int a, int pad, int n);
        cs_open();
        push_tx(cyc + 2, mdl[a]);
        pulse((pad << 4) | a, $urandom_range(2, 4));
        repeat (n) begin
            a = next_addr(a);
            push_tx(cyc + 2, mdl[a]);
            pulse($urandom, $urandom_range(2, 4));
        end
        chk("busy_in_read", int'(bus.busy), 1);
        cs_close();
    endtask

    // Pulses with chip select low must neither write nor disturb tx_data.
    task automatic idle_pulses(int n);
        repeat (n) pulse($urandom, 1);
        chk("tx_idle_unchanged", int'(bus.tx_data), exp_tx);
        chk("busy_idle", int'(bus.busy), 0);
    endtask

    task automatic reset_model();
        for (int i = 0; i < NREG; i++) mdl[i] = int'(init_vals[i]);
        exp_tx = 0;
    endtask

    initial begin
        #(50000 * 10);
        $display("FAIL watchdog: simulation did not finish within the cycle budget");
        $fatal(1);
    end

    initial begin
        int a;
        int d[$];
        for (int i = 0; i < NREG; i++) init_vals[i] = 8'($urandom);
        init_vals[7] = 8'h3E;
        reset_model();
        bus.cs_active = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = '0;
        rst = 1'b1;
        tick(3);
        chk("rst_tx_data", int'(bus.tx_data), 0);
        chk("rst_reg_addr", int'(bus.reg_addr), 0);
        chk("rst_reg_wdata", int'(bus.reg_wdata), 0);
        chk("rst_reg_wr_en", int'(bus.reg_wr_en), 0);
        chk("rst_busy", int'(bus.busy), 0);
        rst = 1'b0;
        tick(2);

        // Single write: 0x83, 0x5C.
        write_txn(3, 0, '{'h5C});
        // Read register 7 (0x3E) after the 0xA5 sync byte.
        read_txn(7, 0, 0);
        // Burst write into the top register (wraps with auto-increment).
        write_txn(15, 0, '{'h11, 'h22});
        read_txn(15, 0, 1);
        idle_pulses(3);

        // Abort: chip select falls with the second data byte.
        cs_open();
        pulse('h8F, 2);
        push_wr(15, 'h33);
        pulse('h33, 2);
        a = next_addr(15);
        push_wr(a, 'h44);
        bus.cs_active = 1'b0;
        pulse('h44, 0);
        chk("busy_abort_strobe", int'(bus.busy), 1);
        tick(1);
        chk("busy_abort_done", int'(bus.busy), 0);
        idle_pulses(2);

        // Abort: chip select falls one cycle after the data byte.
        cs_open();
        pulse('h8F, 2);
        push_wr(15, 'h55);
        pulse('h55, 2);
        a = next_addr(15);
        push_wr(a, 'h66);
        bus.rx_data  = 8'h66;
        bus.rx_valid = 1'b1;
        tick(1);
        bus.rx_valid  = 1'b0;
        bus.cs_active = 1'b0;
        tick(1);
        chk("busy_late_abort", int'(bus.busy), 0);
        idle_pulses(2);

        // Reset mid-burst: the byte coinciding with reset is never written.
        cs_open();
        pulse('h8F, 2);
        push_wr(15, 'h77);
        pulse('h77, 2);
        bus.rx_data  = 8'h88;
        bus.rx_valid = 1'b1;
        rst = 1'b1;
        tick(1);
        bus.rx_valid = 1'b0;
        reset_model();
        chk("midrst_wr_en", int'(bus.reg_wr_en), 0);
        chk("midrst_tx", int'(bus.tx_data), 0);
        chk("midrst_addr", int'(bus.reg_addr), 0);
        chk("midrst_wdata", int'(bus.reg_wdata), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        // Release with chip select still high: a new transaction starts.
        rst = 1'b0;
        push_tx(cyc + 1, 'hA5);
        tick(1);
        chk("busy_after_rst", int'(bus.busy), 1);
        tick(1);
        pulse('h85, 2);
        push_wr(5, 'h9A);
        pulse('h9A, 2);
        cs_close();
        read_txn(5, 0, 0);

        // Randomized mix of transactions.
        for (int t = 0; t < 30; t++) begin
            a = $urandom_range(0, NREG - 1);
            if ($urandom_range(0, 1) == 1) begin
                d.delete();
                repeat ($urandom_range(1, 4)) d.push_back(int'(8'($urandom)));
                write_txn(a, $urandom_range(0, 7), d);
            end else begin
                read_txn(a, $urandom_range(0, 7), $urandom_range(0, 3));
            end
            if ($urandom_range(0, 3) == 0) idle_pulses($urandom_range(1, 3));
        end

        tick(5);
        chk("wr_queue_drained", wr_q.size(), 0);
        chk("tx_queue_drained", rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 Parameter D_W, default 8: SPI byte and register width.
REQ-002 Parameter ADDR_W, default 4: register address width (16 registers); ADDR_W SHALL be at most D_W-1.
REQ-003 m_clk  in  1: single system clock; all logic SHALL be synchronous to its rising edge.
REQ-004 rst  in  1: reset, synchronous and active-high.
REQ-005 cs_active  in  1: chip select, already synchronized to m_clk; 1 = transaction open.
REQ-006 rx_valid  in  1: one-cycle pulse; a full SPI byte has been received.
REQ-007 rx_data  in  D_W: received byte; valid only while rx_valid=1.
REQ-008 tx_data  out  D_W: byte the SPI peripheral loads for the next transfer.
REQ-009 reg_addr  out  ADDR_W: register-bank address.
REQ-010 reg_wdata  out  D_W: register write data.
REQ-011 reg_wr_en  out  1: one-cycle register write strobe.
REQ-012 reg_rdata  in  D_W: register-bank read data, combinational from reg_addr.
REQ-013 busy  out  1: high whenever the state is not IDLE.

Function
REQ-014 The controller SHALL use states IDLE, CMD, WDATA and RDATA.
REQ-015 IDLE -> CMD SHALL occur on the first cycle with cs_active=1; on that entry tx_data SHALL be set to 8'hA5 (sync byte).
REQ-016 In CMD, on rx_valid the controller SHALL latch reg_addr from rx_data[ADDR_W-1:0] and decode rx_data[D_W-1] as direction: 1 = write, 0 = read.
REQ-017 Write command SHALL move CMD -> WDATA.
REQ-018 Read command SHALL move CMD -> RDATA, and tx_data SHALL equal reg_rdata at the latched address exactly 2 cycles after the rx_valid pulse.
REQ-019 In WDATA, each rx_valid SHALL produce reg_wr_en=1 for one cycle on the next cycle, with reg_wdata=rx_data and reg_addr = current address.
REQ-020 In RDATA, each rx_valid (content ignored) SHALL advance the address as configured, and tx_data SHALL reload from reg_rdata 2 cycles after the pulse.
REQ-021 reg_wr_en SHALL never assert outside WDATA.
REQ-022 cs_active=0 in any state SHALL return the FSM to IDLE on the next edge and abort the transaction.
REQ-023 An rx_valid coincident with cs_active falling SHALL still be fully processed (including its write strobe) before IDLE; no later strobe SHALL occur.
REQ-024 rx_valid while in IDLE SHALL be ignored.
REQ-025 An address advance from 2^ADDR_W-1 SHALL wrap to 0.

Reset
REQ-026 While rst=1 the FSM SHALL be IDLE and tx_data=0, reg_addr=0, reg_wdata=0, reg_wr_en=0, busy=0.
REQ-027 rst SHALL take priority over all other inputs, including mid-transaction: any pending write strobe is dropped.
REQ-028 After rst releases with cs_active=1, the controller SHALL enter CMD on the next edge; a new transaction needs no cs_active toggle.

Configuration
REQ-029 Macro SPI_REG_AUTOINC_EN, when defined, SHALL advance reg_addr by 1 after each data byte in WDATA and RDATA (write: the cycle after the strobe).
REQ-030 Without SPI_REG_AUTOINC_EN, reg_addr SHALL stay at the commanded address for the whole transaction.

Verification
REQ-031 Write: cs=1, bytes 0x83, 0x5C -> one reg_wr_en pulse, addr 3, wdata 0x5C, busy=1 until cs=0.
REQ-032 Read: register 7 = 0x3E; cs=1, byte 0x07 -> tx_data=0x3E two cycles after the pulse; first tx_data after cs rise = 0xA5.
REQ-033 Burst write with AUTOINC_EN: 0x8F, 0x11, 0x22 -> writes addr 15 = 0x11, then addr 0 = 0x22 (wrap); without the macro, both writes go to addr 15.
REQ-034 Abort: cs falls in the same cycle as the second data byte pulse (0x8F, 0x11, 0x22) -> that write is still strobed; cs falls one cycle later -> the write is strobed; no further strobes; busy=0 next cycle.
REQ-035 Reset mid-burst: rst=1 in WDATA with a write pending -> no strobe, all outputs 0, state IDLE.
REQ-036 rx_valid pulses while cs=0 -> no reg_wr_en, tx_data unchanged.
